// File: rtl/instruction_encoder.sv
// rtl/instruction_encoder.sv - RV64G instruction encoder with a 2-entry result FIFO.
// Optional FP encoding (FLx/FSx/R4 forms) is built when INSTRUCTION_ENCODER_FP_EN is defined.
`timescale 1ns/1ps

package rv64g_pkg;

    typedef enum logic [6:0] {
        INVALID,
        LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LD, LBU, LHU, LWU,
        SB, SH, SW, SD,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI,
        SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        ADDIW, SLLIW, SRLIW, SRAIW,
        ADDW, SUBW, SLLW, SRLW, SRAW,
        FENCE, FENCE_TSO, PAUSE, ECALL, EBREAK,
        CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI,
        FLH, FLW, FLD, FSH, FSW, FSD,
        FMADD_S, FMSUB_S, FNMSUB_S, FNMADD_S,
        FMADD_D, FMSUB_D, FNMSUB_D, FNMADD_D,
        FMADD_H, FMSUB_H, FNMSUB_H, FNMADD_H
    } funct_t;

    typedef struct packed {
        funct_t      funct;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [63:0] imm;
        logic [11:0] csr;
        logic [2:0]  rm;
    } decoded_instr_t;

endpackage

module instruction_encoder
    import rv64g_pkg::*;
(
    input  logic           clk_i,
    input  logic           arst_i,
    input  decoded_instr_t cmd_i,
    input  logic           cmd_valid_i,
    output logic           cmd_ready_o,
    output logic [31:0]    code_o,
    output logic           illegal_o,
    output logic           code_valid_o,
    input  logic           code_ready_i,
    output logic [7:0]     illegal_count_o
);

    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_IMM     = 7'b0010011;
    localparam logic [6:0] OP_IMM32   = 7'b0011011;
    localparam logic [6:0] OP_REG     = 7'b0110011;
    localparam logic [6:0] OP_REG32   = 7'b0111011;
    localparam logic [6:0] OP_SYSTEM  = 7'b1110011;

    localparam logic [3:0] FMT_ILL    = 4'd0;
    localparam logic [3:0] FMT_R      = 4'd1;
    localparam logic [3:0] FMT_I      = 4'd2;
    localparam logic [3:0] FMT_SH6    = 4'd3;
    localparam logic [3:0] FMT_SH5    = 4'd4;
    localparam logic [3:0] FMT_S      = 4'd5;
    localparam logic [3:0] FMT_B      = 4'd6;
    localparam logic [3:0] FMT_J      = 4'd7;
    localparam logic [3:0] FMT_U      = 4'd8;
    localparam logic [3:0] FMT_CSR    = 4'd9;
    localparam logic [3:0] FMT_CSRI   = 4'd10;
    localparam logic [3:0] FMT_FIXED  = 4'd11;

`ifdef INSTRUCTION_ENCODER_FP_EN
    localparam logic [6:0] OP_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] OP_STORE_FP = 7'b0100111;
    localparam logic [6:0] OP_FMADD    = 7'b1000011;
    localparam logic [6:0] OP_FMSUB    = 7'b1000111;
    localparam logic [6:0] OP_FNMSUB   = 7'b1001011;
    localparam logic [6:0] OP_FNMADD   = 7'b1001111;
    localparam logic [3:0] FMT_R4      = 4'd12;
`endif

    logic [3:0]  fmt;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] fixed_word;
    logic [1:0]  fp_fmt;
    logic        fits12;
    logic        fits13;
    logic        fits21;
    logic [31:0] enc_code;
    logic        enc_ill;

    // An immediate is representable when every bit above the field matches its sign bit.
    assign fits12 = (&cmd_i.imm[63:11]) | ~(|cmd_i.imm[63:11]);
    assign fits13 = (&cmd_i.imm[63:12]) | ~(|cmd_i.imm[63:12]);
    assign fits21 = (&cmd_i.imm[63:20]) | ~(|cmd_i.imm[63:20]);

    always_comb begin
        fmt        = FMT_ILL;
        opc        = 7'b0;
        f3         = 3'b000;
        f7         = 7'b0;
        fixed_word = 32'h0;
        fp_fmt     = 2'b00;
        case (cmd_i.funct)
            LUI:       begin fmt = FMT_U; opc = OP_LUI; end
            AUIPC:     begin fmt = FMT_U; opc = OP_AUIPC; end
            JAL:       begin fmt = FMT_J; opc = OP_JAL; end
            JALR:      begin fmt = FMT_I; opc = OP_JALR; end
            BEQ:       begin fmt = FMT_B; opc = OP_BRANCH; f3 = 3'b000; end
            BNE:       begin fmt = FMT_B; opc = OP_BRANCH; f3 = 3'b001; end
            BLT:       begin fmt = FMT_B; opc = OP_BRANCH; f3 = 3'b100; end
            BGE:       begin fmt = FMT_B; opc = OP_BRANCH; f3 = 3'b101; end
            BLTU:      begin fmt = FMT_B; opc = OP_BRANCH; f3 = 3'b110; end
            BGEU:      begin fmt = FMT_B; opc = OP_BRANCH; f3 = 3'b111; end
            LB:        begin fmt = FMT_I; opc = OP_LOAD; f3 = 3'b000; end
            LH:        begin fmt = FMT_I; opc = OP_LOAD; f3 = 3'b001; end
            LW:        begin fmt = FMT_I; opc = OP_LOAD; f3 = 3'b010; end
            LD:        begin fmt = FMT_I; opc = OP_LOAD; f3 = 3'b011; end
            LBU:       begin fmt = FMT_I; opc = OP_LOAD; f3 = 3'b100; end
            LHU:       begin fmt = FMT_I; opc = OP_LOAD; f3 = 3'b101; end
            LWU:       begin fmt = FMT_I; opc = OP_LOAD; f3 = 3'b110; end
            SB:        begin fmt = FMT_S; opc = OP_STORE; f3 = 3'b000; end
            SH:        begin fmt = FMT_S; opc = OP_STORE; f3 = 3'b001; end
            SW:        begin fmt = FMT_S; opc = OP_STORE; f3 = 3'b010; end
            SD:        begin fmt = FMT_S; opc = OP_STORE; f3 = 3'b011; end
            ADDI:      begin fmt = FMT_I; opc = OP_IMM; f3 = 3'b000; end
            SLTI:      begin fmt = FMT_I; opc = OP_IMM; f3 = 3'b010; end
            SLTIU:     begin fmt = FMT_I; opc = OP_IMM; f3 = 3'b011; end
            XORI:      begin fmt = FMT_I; opc = OP_IMM; f3 = 3'b100; end
            ORI:       begin fmt = FMT_I; opc = OP_IMM; f3 = 3'b110; end
            ANDI:      begin fmt = FMT_I; opc = OP_IMM; f3 = 3'b111; end
            SLLI:      begin fmt = FMT_SH6; opc = OP_IMM; f3 = 3'b001; end
            SRLI:      begin fmt = FMT_SH6; opc = OP_IMM; f3 = 3'b101; end
            SRAI:      begin fmt = FMT_SH6; opc = OP_IMM; f3 = 3'b101; f7 = 7'b0100000; end
            ADD:       begin fmt = FMT_R; opc = OP_REG; f3 = 3'b000; end
            SUB:       begin fmt = FMT_R; opc = OP_REG; f3 = 3'b000; f7 = 7'b0100000; end
            SLL:       begin fmt = FMT_R; opc = OP_REG; f3 = 3'b001; end
            SLT:       begin fmt = FMT_R; opc = OP_REG; f3 = 3'b010; end
            SLTU:      begin fmt = FMT_R; opc = OP_REG; f3 = 3'b011; end
            XOR:       begin fmt = FMT_R; opc = OP_REG; f3 = 3'b100; end
            SRL:       begin fmt = FMT_R; opc = OP_REG; f3 = 3'b101; end
            SRA:       begin fmt = FMT_R; opc = OP_REG; f3 = 3'b101; f7 = 7'b0100000; end
            OR:        begin fmt = FMT_R; opc = OP_REG; f3 = 3'b110; end
            AND:       begin fmt = FMT_R; opc = OP_REG; f3 = 3'b111; end
            ADDIW:     begin fmt = FMT_I; opc = OP_IMM32; f3 = 3'b000; end
            SLLIW:     begin fmt = FMT_SH5; opc = OP_IMM32; f3 = 3'b001; end
            SRLIW:     begin fmt = FMT_SH5; opc = OP_IMM32; f3 = 3'b101; end
            SRAIW:     begin fmt = FMT_SH5; opc = OP_IMM32; f3 = 3'b101; f7 = 7'b0100000; end
            ADDW:      begin fmt = FMT_R; opc = OP_REG32; f3 = 3'b000; end
            SUBW:      begin fmt = FMT_R; opc = OP_REG32; f3 = 3'b000; f7 = 7'b0100000; end
            SLLW:      begin fmt = FMT_R; opc = OP_REG32; f3 = 3'b001; end
            SRLW:      begin fmt = FMT_R; opc = OP_REG32; f3 = 3'b101; end
            SRAW:      begin fmt = FMT_R; opc = OP_REG32; f3 = 3'b101; f7 = 7'b0100000; end
            FENCE:     begin fmt = FMT_FIXED; fixed_word = 32'h0FF0000F; end
            FENCE_TSO: begin fmt = FMT_FIXED; fixed_word = 32'h8330000F; end
            PAUSE:     begin fmt = FMT_FIXED; fixed_word = 32'h0100000F; end
            ECALL:     begin fmt = FMT_FIXED; fixed_word = 32'h00000073; end
            EBREAK:    begin fmt = FMT_FIXED; fixed_word = 32'h00100073; end
            CSRRW:     begin fmt = FMT_CSR; opc = OP_SYSTEM; f3 = 3'b001; end
            CSRRS:     begin fmt = FMT_CSR; opc = OP_SYSTEM; f3 = 3'b010; end
            CSRRC:     begin fmt = FMT_CSR; opc = OP_SYSTEM; f3 = 3'b011; end
            CSRRWI:    begin fmt = FMT_CSRI; opc = OP_SYSTEM; f3 = 3'b101; end
            CSRRSI:    begin fmt = FMT_CSRI; opc = OP_SYSTEM; f3 = 3'b110; end
            CSRRCI:    begin fmt = FMT_CSRI; opc = OP_SYSTEM; f3 = 3'b111; end
`ifdef INSTRUCTION_ENCODER_FP_EN
            FLH:       begin fmt = FMT_I; opc = OP_LOAD_FP; f3 = 3'b001; end
            FLW:       begin fmt = FMT_I; opc = OP_LOAD_FP; f3 = 3'b010; end
            FLD:       begin fmt = FMT_I; opc = OP_LOAD_FP; f3 = 3'b011; end
            FSH:       begin fmt = FMT_S; opc = OP_STORE_FP; f3 = 3'b001; end
            FSW:       begin fmt = FMT_S; opc = OP_STORE_FP; f3 = 3'b010; end
            FSD:       begin fmt = FMT_S; opc = OP_STORE_FP; f3 = 3'b011; end
            FMADD_S:   begin fmt = FMT_R4; opc = OP_FMADD;  fp_fmt = 2'b00; end
            FMSUB_S:   begin fmt = FMT_R4; opc = OP_FMSUB;  fp_fmt = 2'b00; end
            FNMSUB_S:  begin fmt = FMT_R4; opc = OP_FNMSUB; fp_fmt = 2'b00; end
            FNMADD_S:  begin fmt = FMT_R4; opc = OP_FNMADD; fp_fmt = 2'b00; end
            FMADD_D:   begin fmt = FMT_R4; opc = OP_FMADD;  fp_fmt = 2'b01; end
            FMSUB_D:   begin fmt = FMT_R4; opc = OP_FMSUB;  fp_fmt = 2'b01; end
            FNMSUB_D:  begin fmt = FMT_R4; opc = OP_FNMSUB; fp_fmt = 2'b01; end
            FNMADD_D:  begin fmt = FMT_R4; opc = OP_FNMADD; fp_fmt = 2'b01; end
            FMADD_H:   begin fmt = FMT_R4; opc = OP_FMADD;  fp_fmt = 2'b10; end
            FMSUB_H:   begin fmt = FMT_R4; opc = OP_FMSUB;  fp_fmt = 2'b10; end
            FNMSUB_H:  begin fmt = FMT_R4; opc = OP_FNMSUB; fp_fmt = 2'b10; end
            FNMADD_H:  begin fmt = FMT_R4; opc = OP_FNMADD; fp_fmt = 2'b10; end
`endif
            default:   fmt = FMT_ILL;
        endcase
    end

`ifndef INSTRUCTION_ENCODER_FP_EN
    logic unused_fp;
    assign unused_fp = ^{cmd_i.rm, fp_fmt};
`endif

    always_comb begin
        enc_code = 32'h0;
        enc_ill  = 1'b0;
        case (fmt)
            FMT_R: enc_code = {f7, cmd_i.rs2, cmd_i.rs1, f3, cmd_i.rd, opc};
            FMT_I: begin
                enc_code = {cmd_i.imm[11:0], cmd_i.rs1, f3, cmd_i.rd, opc};
                enc_ill  = !fits12;
            end
            FMT_SH6: begin
                enc_code = {f7[6:1], cmd_i.imm[5:0], cmd_i.rs1, f3, cmd_i.rd, opc};
                enc_ill  = |cmd_i.imm[63:6];
            end
            FMT_SH5: begin
                enc_code = {f7, cmd_i.imm[4:0], cmd_i.rs1, f3, cmd_i.rd, opc};
                enc_ill  = |cmd_i.imm[63:5];
            end
            FMT_S: begin
                enc_code = {cmd_i.imm[11:5], cmd_i.rs2, cmd_i.rs1, f3, cmd_i.imm[4:0], opc};
                enc_ill  = !fits12;
            end
            FMT_B: begin
                enc_code = {cmd_i.imm[12], cmd_i.imm[10:5], cmd_i.rs2, cmd_i.rs1, f3,
                            cmd_i.imm[4:1], cmd_i.imm[11], opc};
                enc_ill  = !fits13;
            end
            FMT_J: begin
                enc_code = {cmd_i.imm[20], cmd_i.imm[10:1], cmd_i.imm[11], cmd_i.imm[19:12],
                            cmd_i.rd, opc};
                enc_ill  = !fits21;
            end
            FMT_U:     enc_code = {cmd_i.imm[31:12], cmd_i.rd, opc};
            FMT_CSR:   enc_code = {cmd_i.csr, cmd_i.rs1, f3, cmd_i.rd, opc};
            FMT_CSRI:  enc_code = {cmd_i.csr, cmd_i.imm[4:0], f3, cmd_i.rd, opc};
            FMT_FIXED: enc_code = fixed_word;
`ifdef INSTRUCTION_ENCODER_FP_EN
            // rs3 travels in imm[4:0]
            FMT_R4:    enc_code = {cmd_i.imm[4:0], fp_fmt, cmd_i.rs2, cmd_i.rs1, cmd_i.rm,
                                   cmd_i.rd, opc};
`endif
            default:   enc_ill = 1'b1;
        endcase
        if (enc_ill) begin
            enc_code = 32'h0;
        end
    end

    logic [32:0] mem_q [2];
    logic [32:0] mem_d [2];
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [7:0]  ill_cnt_q, ill_cnt_d;
    logic        push;
    logic        pop;
    logic [32:0] head;

    assign cmd_ready_o     = (count_q != 2'd2);
    assign code_valid_o    = (count_q != 2'd0);
    assign push            = cmd_valid_i && cmd_ready_o;
    assign pop             = code_valid_o && code_ready_i;
    assign head            = mem_q[rd_ptr_q];
    assign code_o          = code_valid_o ? head[31:0] : 32'h0;
    assign illegal_o       = code_valid_o & head[32];
    assign illegal_count_o = ill_cnt_q;

    always_comb begin
        mem_d     = mem_q;
        count_d   = count_q + {1'b0, push} - {1'b0, pop};
        rd_ptr_d  = rd_ptr_q ^ pop;
        wr_ptr_d  = wr_ptr_q ^ push;
        ill_cnt_d = ill_cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = {enc_ill, enc_code};
            if (enc_ill && ill_cnt_q != 8'hFF) begin
                ill_cnt_d = ill_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            mem_q[0]  <= '0;
            mem_q[1]  <= '0;
            count_q   <= 2'd0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            ill_cnt_q <= 8'd0;
        end else begin
            mem_q[0]  <= mem_d[0];
            mem_q[1]  <= mem_d[1];
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            ill_cnt_q <= ill_cnt_d;
        end
    end

endmodule
